// File: rtl/hvsp_responder.sv
// HVSP target-side responder: frames 11-bit SDI/SII sequences clocked on SCI,
// reports each received byte pair and shifts a held byte back out on SDO.
module hvsp_responder #(
   parameter int TIMEOUT = 4095
) (
   input  logic       osc,
   input  logic       rst,
   input  logic       prog_en,
   input  logic       sci,
   input  logic       sdi,
   input  logic       sii,
   output logic       sdo,
   output logic       sdo_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic [7:0] rx_sdi,
   output logic [7:0] rx_sii,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       timeout,
   output logic       busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state, state_n;
   logic [1:0]    sci_sync, sdi_sync, sii_sync;
   logic          sci_prev, pe_q;
   logic [3:0]    bit_cnt;
   logic [9:0]    sdi_shift, sii_shift, tx_shift;
   logic [7:0]    tx_hold;
   logic [TW-1:0] tmo_cnt;
   logic          sci_s, sdi_s, sii_s, rise, fall, expire;

   assign sci_s  = sci_sync[1];
   assign sdi_s  = sdi_sync[1];
   assign sii_s  = sii_sync[1];
   assign rise   = sci_s & ~sci_prev;
   assign fall   = ~sci_s & sci_prev;
   // any SCI edge restarts the inactivity window, so an edge beats expiry
   assign expire = (state == SHIFT) && !(rise || fall) && (tmo_cnt == TW'(TIMEOUT - 1));
   assign sdo_oe = pe_q;
   assign busy   = (bit_cnt != 4'd0);

   always_ff @(posedge osc) begin
      if (rst) begin
         sci_sync <= '0;
         sdi_sync <= '0;
         sii_sync <= '0;
         sci_prev <= 1'b0;
         pe_q     <= 1'b0;
      end else begin
         sci_sync <= {sci_sync[0], sci};
         sdi_sync <= {sdi_sync[0], sdi};
         sii_sync <= {sii_sync[0], sii};
         sci_prev <= sci_sync[1];
         pe_q     <= prog_en;
      end
   end

   always_ff @(posedge osc) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (rise) state_n = SHIFT;
         SHIFT: begin
            if (rise && bit_cnt == 4'd10) state_n = DONE;
            else if (expire)              state_n = IDLE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (!pe_q) state_n = IDLE;
   end

   // Shift regs hold frame bits 10..1 after the 10th rise; bit 0 is taken
   // straight from the synchronizer on the 11th rise.
   always_ff @(posedge osc) begin
      if (rst) begin
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
         sdi_shift <= '0;
         sii_shift <= '0;
         tx_shift  <= '0;
         tx_hold   <= '0;
         sdo       <= 1'b0;
         rx_sdi    <= '0;
         rx_sii    <= '0;
         rx_err    <= 1'b0;
         rx_valid  <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         timeout  <= 1'b0;
         if (tx_load) tx_hold <= tx_data;
         if (!pe_q) begin
            bit_cnt <= '0;
            tmo_cnt <= '0;
            sdo     <= 1'b0;
         end else begin
            if (rise || fall || bit_cnt == 4'd0) tmo_cnt <= '0;
            else                                 tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
               IDLE: if (rise) begin
                  sdi_shift <= {9'd0, sdi_s};
                  sii_shift <= {9'd0, sii_s};
                  tx_shift  <= {tx_hold, 2'b00};
                  bit_cnt   <= 4'd1;
               end
               SHIFT: begin
                  if (rise) begin
                     sdi_shift <= {sdi_shift[8:0], sdi_s};
                     sii_shift <= {sii_shift[8:0], sii_s};
                     if (bit_cnt == 4'd10) begin
                        rx_sdi   <= sdi_shift[8:1];
                        rx_sii   <= sii_shift[8:1];
                        rx_err   <= |{sdi_shift[9], sdi_shift[0], sdi_s,
                                      sii_shift[9], sii_shift[0], sii_s};
                        rx_valid <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end else if (expire) begin
                     bit_cnt <= '0;
                     tmo_cnt <= '0;
                     sdo     <= 1'b0;
                     timeout <= 1'b1;
                  end
                  if (fall) begin
                     sdo      <= tx_shift[9];
                     tx_shift <= {tx_shift[8:0], 1'b0};
                  end
               end
               DONE: begin
                  bit_cnt <= '0;
                  sdo     <= 1'b0;
               end
               default: bit_cnt <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hvsp_responder.sv
// Directed bench for hvsp_responder: drives HVSP frames at initiator timing
// and checks decoded bytes, returned SDO bits, timeout and abort behaviour.
module tb_hvsp_responder;

   logic       osc = 1'b0, rst = 1'b1, prog_en = 1'b0;
   logic       sci = 1'b0, sdi = 1'b0, sii = 1'b0, tx_load = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       sdo, sdo_oe, rx_valid, rx_err, timeout, busy;
   logic [7:0] rx_sdi, rx_sii;

   int passed = 0, total = 0;
   int n_valid = 0, n_tmo = 0;

   hvsp_responder dut (
      .osc(osc), .rst(rst), .prog_en(prog_en), .sci(sci), .sdi(sdi), .sii(sii),
      .sdo(sdo), .sdo_oe(sdo_oe), .tx_data(tx_data), .tx_load(tx_load),
      .rx_sdi(rx_sdi), .rx_sii(rx_sii), .rx_valid(rx_valid), .rx_err(rx_err),
      .timeout(timeout), .busy(busy)
   );

   always #5 osc = ~osc;

   always @(posedge osc) begin
      if (rx_valid) n_valid <= n_valid + 1;
      if (timeout)  n_tmo   <= n_tmo + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge osc);
   endtask

   // One bit per 8 cycles (low 4, high 4); sdo is sampled just before each rise.
   // ld pulses tx_load in the cycle the first rise is detected inside the DUT.
   task automatic frame(input logic [10:0] d, input logic [10:0] s, input int nbits,
                        input bit ld, output logic [10:0] so);
      so = '0;
      for (int b = 10; b > 10 - nbits; b--) begin
         sdi = d[b];
         sii = s[b];
         wait_n(4);
         so[b] = sdo;
         sci = 1'b1;
         wait_n(2);
         if (ld && b == 10) tx_load = 1'b1;
         wait_n(1);
         tx_load = 1'b0;
         wait_n(1);
         sci = 1'b0;
      end
   endtask

   function automatic logic [10:0] fr(input logic [7:0] v);
      return {1'b0, v, 2'b00};
   endfunction

   initial begin
      logic [10:0] so;
      rst = 1'b1;
      prog_en = 1'b1;
      wait_n(3);
      chk("rst_sdo", sdo, 0);
      chk("rst_sdo_oe", sdo_oe, 0);
      chk("rst_rx_sdi", rx_sdi, 0);
      chk("rst_rx_sii", rx_sii, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_err", rx_err, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      wait_n(3);
      chk("sdo_oe_on", sdo_oe, 1);

      // plain frame
      frame(fr(8'h4C), fr(8'h4C), 11, 1'b0, so);
      wait_n(10);
      chk("f1_nvalid", n_valid, 1);
      chk("f1_rx_sdi", rx_sdi, 8'h4C);
      chk("f1_rx_sii", rx_sii, 8'h4C);
      chk("f1_rx_err", rx_err, 0);
      chk("f1_busy", busy, 0);
      chk("f1_sdo", so, 11'h000);

      // returned byte, twice without reload
      tx_data = 8'hA5;
      tx_load = 1'b1;
      wait_n(1);
      tx_load = 1'b0;
      frame(fr(8'h11), fr(8'h22), 11, 1'b0, so);
      wait_n(10);
      chk("f2_sdo", so, 11'b01010010100);
      chk("f2_nvalid", n_valid, 2);
      chk("f2_rx_sdi", rx_sdi, 8'h11);
      chk("f2_rx_sii", rx_sii, 8'h22);
      frame(fr(8'h33), fr(8'h44), 11, 1'b0, so);
      wait_n(10);
      chk("f3_sdo", so, 11'b01010010100);
      chk("f3_nvalid", n_valid, 3);

      // framing errors: SDI bit 0, then SII bit 10, then clean frame clears it
      frame({1'b0, 8'h12, 2'b01}, fr(8'h34), 11, 1'b0, so);
      wait_n(10);
      chk("e1_nvalid", n_valid, 4);
      chk("e1_rx_sdi", rx_sdi, 8'h12);
      chk("e1_rx_sii", rx_sii, 8'h34);
      chk("e1_rx_err", rx_err, 1);
      frame(fr(8'h56), {1'b1, 8'h78, 2'b00}, 11, 1'b0, so);
      wait_n(10);
      chk("e2_rx_err", rx_err, 1);
      chk("e2_rx_sii", rx_sii, 8'h78);
      frame(fr(8'h5A), fr(8'hC3), 11, 1'b0, so);
      wait_n(10);
      chk("e3_rx_err", rx_err, 0);
      chk("e3_nvalid", n_valid, 6);

      // inactivity timeout after 5 rises
      frame(fr(8'h4C), fr(8'h4C), 5, 1'b0, so);
      chk("t_busy_mid", busy, 1);
      wait_n(4000);
      chk("t_early", n_tmo, 0);
      chk("t_busy_wait", busy, 1);
      wait_n(200);
      chk("t_ntmo", n_tmo, 1);
      chk("t_busy_after", busy, 0);
      chk("t_sdo", sdo, 0);
      chk("t_nvalid", n_valid, 6);
      chk("t_rx_sdi_kept", rx_sdi, 8'h5A);
      frame(fr(8'h81), fr(8'h7E), 11, 1'b0, so);
      wait_n(10);
      chk("t2_rx_sdi", rx_sdi, 8'h81);
      chk("t2_rx_sii", rx_sii, 8'h7E);
      chk("t2_nvalid", n_valid, 7);
      chk("t2_ntmo", n_tmo, 1);

      // prog_en dropped mid-frame
      frame(fr(8'hFF), fr(8'hFF), 6, 1'b0, so);
      prog_en = 1'b0;
      wait_n(5);
      chk("p_sdo_oe", sdo_oe, 0);
      chk("p_busy", busy, 0);
      chk("p_sdo", sdo, 0);
      wait_n(4200);
      chk("p_ntmo", n_tmo, 1);
      chk("p_nvalid", n_valid, 7);
      prog_en = 1'b1;
      wait_n(5);
      frame(fr(8'hFF), fr(8'h00), 11, 1'b0, so);
      wait_n(10);
      chk("p2_rx_sdi", rx_sdi, 8'hFF);
      chk("p2_rx_sii", rx_sii, 8'h00);
      chk("p2_nvalid", n_valid, 8);
      chk("p2_sdo", so, 11'b01010010100);

      // reset mid-frame, then load coincident with the next frame start
      frame(fr(8'h99), fr(8'h99), 4, 1'b0, so);
      rst = 1'b1;
      wait_n(2);
      chk("r_busy", busy, 0);
      chk("r_rx_sdi", rx_sdi, 0);
      chk("r_sdo_oe", sdo_oe, 0);
      rst = 1'b0;
      wait_n(3);
      chk("r_nvalid", n_valid, 8);
      tx_data = 8'h3C;
      frame(fr(8'h0F), fr(8'hF0), 11, 1'b1, so);
      wait_n(10);
      chk("r1_sdo", so, 11'h000);
      chk("r1_rx_sdi", rx_sdi, 8'h0F);
      chk("r1_nvalid", n_valid, 9);
      frame(fr(8'h01), fr(8'h80), 11, 1'b0, so);
      wait_n(10);
      chk("r2_sdo", so, {1'b0, 8'h3C, 2'b00});
      chk("r2_rx_sii", rx_sii, 8'h80);
      chk("r2_nvalid", n_valid, 10);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hvsp_responder.md
# hvsp_responder

Target-side responder for the AVR high-voltage serial programming (HVSP) link. It emulates the ATtiny HVSP slave in FPGA fabric: it frames the 11-bit SDI/SII sequences clocked in on SCI, hands each received instruction/data byte pair to a backend, and shifts a backend-supplied byte out on SDO. It sits on the ZIF pins opposite the HVSP initiator bitstream and serves as a loopback DUT model for bring-up and regression of the programmer side.

## Interface
- TIMEOUT, 4095: osc cycles of SCI inactivity mid-frame before the frame is aborted (≈341 µs at 12 MHz).
- osc  in  1  12 MHz clock; sole clock domain.
- rst  in  1  reset; **synchronous, active-high**.
- prog_en  in  1  programming mode active (HV reset detected); low forces idle.
- sci  in  1  serial clock from initiator (asynchronous pin).
- sdi  in  1  serial data in (asynchronous pin).
- sii  in  1  serial instruction in (asynchronous pin).
- sdo  out  1  serial data out value.
- sdo_oe  out  1  SDO drive enable; equals registered prog_en.
- tx_data  in  8  byte to be returned in the next frame.
- tx_load  in  1  one-cycle strobe; latches tx_data into the holding register.
- rx_sdi  out  8  SDI frame bits 9:2 of last completed frame.
- rx_sii  out  8  SII frame bits 9:2 of last completed frame.
- rx_valid  out  1  one-cycle pulse: rx_sdi/rx_sii/rx_err updated.
- rx_err  out  1  framing error on last frame (valid with rx_valid).
- timeout  out  1  one-cycle pulse: frame aborted by inactivity.
- busy  out  1  high while a frame is in progress (bit_cnt ≠ 0).

## Operation
- Synchronizers: sci, sdi, sii each pass a 2-FF synchronizer; a third register on SCI gives sci_prev. Rise = sync & !prev; fall = !sync & prev. SDI/SII sampled from their synchronized copies in the same cycle as the detected rise.
- Frame: 11 bits, MSB (bit 10) first. bit_cnt 0..10 counts received rises.
- States: IDLE (bit_cnt=0, waiting for rise), SHIFT (1≤bit_cnt≤10), DONE (single cycle after 11th rise).
- IDLE, rise: capture bit 10 into rx shift regs; load tx shift reg with {0, tx_hold, 0, 0}; bit_cnt←1; enter SHIFT.
- SHIFT, rise: shift SDI/SII into rx shift regs; bit_cnt+1; on 11th rise go DONE.
- Any state, fall while frame active: tx shift reg shifts left by one; sdo = tx_shift[10]. In IDLE sdo = 0.
- DONE: rx_sdi←sdi_shift[9:2], rx_sii←sii_shift[9:2]; rx_err = 1 if any of SDI/SII bits 10,1,0 is 1; rx_valid pulses; bit_cnt←0; IDLE.
- tx_load: tx_hold←tx_data any time; a load during a frame affects only the next frame.
- Timeout: counter reset on every SCI edge; counts while bit_cnt≠0; reaching TIMEOUT → bit_cnt←0, sdo←0, timeout pulse, no rx_valid, rx_* unchanged.
- prog_en low (registered): bit_cnt←0, counters cleared, sdo=0, sdo_oe=0; no rx_valid/timeout pulses. Edges ignored.
- Reset values: sdo 0, sdo_oe 0, rx_sdi 0x00, rx_sii 0x00, rx_valid 0, rx_err 0, timeout 0, busy 0, tx_hold 0x00, bit_cnt 0, sync regs 0.

## Timing
- Pin-to-edge-detect latency: 3 osc cycles (2 sync + edge register).
- Input requirement: SCI high and low each ≥3 osc cycles; SDI/SII stable ≥3 cycles before and ≥1 cycle after SCI rise at pin.
- sdo update: registered, 3 cycles after SCI fall at pin (4 cycles counting output register); the initiator samples ≥6 cycles after rise, so a bit driven after fall k is valid at rise k+1.
- rx_valid: 1 cycle after the cycle detecting the 11th rise (4 cycles after pin edge).
- Simultaneous tx_load and frame-start rise: frame uses previous tx_hold.
- Simultaneous timeout expiry and SCI edge: edge wins, counter reset.
- rst or prog_en drop mid-frame: frame discarded, no pulses.

## Test plan
- Frame SDI=0x4C, SII=0x4C (framed 0,byte,0,0) at initiator timing (3/3/3/4 cycles) -> one rx_valid, rx_sdi=0x4C, rx_sii=0x4C, rx_err=0.
- tx_load 0xA5 then one frame -> sdo sampled at rises 1..11 reads 0,1,0,1,0,0,1,0,1,0,0; next frame without reload again returns 0xA5.
- Frame with SDI bit 0 = 1, byte 0x12 -> rx_valid, rx_sdi=0x12, rx_err=1.
- 5 rises then SCI idle 4095 cycles -> timeout pulse exactly once, busy 0, no rx_valid; following full frame decodes correctly.
- prog_en dropped after 6 rises -> sdo_oe 0, busy 0, no pulses; re-enable plus frame 0xFF/0x00 -> rx_sdi=0xFF, rx_sii=0x00.
- rst asserted mid-frame, tx_load 0x3C same cycle as first rise of next frame -> that frame returns previous tx_hold (0x00 after reset), following frame returns 0x3C.
